dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of words (legal range 2..2**ADDR_W).
REQ-004 The block SHALL have parameter INIT_VAL, default 0, meaning the DATA_W value written to every word by the init sweep.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are high at a clk edge.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: read data valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: error qualifier of the response.
REQ-016 The block SHALL have port busy, output, 1 bit: init sweep in progress.

Function
REQ-017 The FSM SHALL have states INIT and RUN; INIT -> RUN after the word at DEPTH-1 is written; RUN -> INIT only on reset.
REQ-018 INIT SHALL write INIT_VAL to address sweep_cnt, one word per cycle, with sweep_cnt counting 0..DEPTH-1; the sweep lasts exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in INIT and 0 in RUN; req_ready SHALL be 0 in INIT.
REQ-020 In RUN, req_ready SHALL be 1 unless rsp_valid=1 and rsp_ready=0.
REQ-021 An accepted write SHALL update the word at the edge of acceptance and SHALL produce no response.
REQ-022 An accepted read SHALL assert rsp_valid with rsp_rdata at the following edge (latency 1).
REQ-023 Read-after-write to the same address on consecutive accepted requests SHALL return the newly written data.
REQ-024 A response SHALL hold rsp_valid and rsp_rdata stable until rsp_ready=1; rsp_valid SHALL clear on that edge unless a new read is accepted on the same edge.
REQ-025 A write with req_addr >= DEPTH SHALL be dropped; a read with req_addr >= DEPTH SHALL return 0 with rsp_err=1.
REQ-026 rsp_err SHALL be 0 for in-range reads, except as given in REQ-031.

Reset
REQ-027 Asserting rst at any time, including mid-sweep or with a response pending, SHALL force state INIT, sweep_cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 1, and req_ready 0.
REQ-028 After rst deasserts, the sweep SHALL restart from address 0; any pending response SHALL be discarded.

Configuration
REQ-029 Macro DMEM_PARITY_EN SHALL, when defined, store one even-parity bit per word alongside its data, written by both writes and the init sweep.
REQ-030 Without DMEM_PARITY_EN, no parity storage SHALL exist.
REQ-031 With DMEM_PARITY_EN defined, an in-range read whose stored parity mismatches SHALL return rsp_err=1 with the raw data; without the macro, rsp_err SHALL reflect only out-of-range reads.

Structure
REQ-032 The package dmem_pkg SHALL hold the state enum (INIT, RUN) and the parity helper function.
REQ-033 The storage array SHALL be a sub-module dmem_array with a single synchronous write port and a registered read port, carrying no reset.

Verification
REQ-034 Reset, then count cycles with DEPTH=16 -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 return INIT_VAL.
REQ-035 Write 0xA5 to address 3, then read address 3 on the next cycle -> rsp_valid one cycle after acceptance, rsp_rdata=0xA5, rsp_err=0.
REQ-036 Read address 5 with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_rdata stable for 3 cycles; the response is released when rsp_ready=1.
REQ-037 With DEPTH=200, write 0x11 to address 250, then read address 250 -> rsp_rdata=0, rsp_err=1; no in-range word changed.
REQ-038 Assert rst mid-sweep at count 7 and mid-response -> rsp_valid=0 immediately; the sweep restarts at 0 and busy lasts a full DEPTH cycles.
REQ-039 With DMEM_PARITY_EN defined, force a parity-bit flip at address 9 and read it -> rsp_err=1; the same read without the flip -> rsp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Even parity over a zero-extended word; extra zero bits leave the result unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the data-memory controller plus its busy flag.
interface dmem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port and one registered, enabled read port.
module dmem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: storage carries no reset; the controller's init sweep defines every word.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: init sweep after reset, then 1-cycle-latency reads and
// posted writes. Define DMEM_PARITY_EN to store and check one even-parity bit per word.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              oor_q, oor_d;

    logic              in_range, req_fire, rd_fire, wr_fire;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [DATA_W-1:0] arr_wdata, rd_data;
    logic [WORD_W-1:0] arr_wword, arr_rword;
    logic              par_err;

    assign in_range      = (32'(bus.req_addr) < DEPTH);
    assign bus.busy      = (state_q == INIT);
    assign bus.req_ready = (state_q == RUN) && !(rsp_valid_q && !bus.rsp_ready);
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rd_fire       = req_fire && !bus.req_we;
    assign wr_fire       = req_fire && bus.req_we && in_range;

    // The sweep owns the write port until RUN; out-of-range writes never reach it.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = sweep_cnt_q;
        arr_wdata = INIT_VAL;
        if (state_q == INIT) begin
            arr_we = 1'b1;
        end else if (wr_fire) begin
            arr_we    = 1'b1;
            arr_waddr = bus.req_addr[IDX_W-1:0];
            arr_wdata = bus.req_wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    assign arr_wword = {even_parity(64'(arr_wdata)), arr_wdata};
    assign rd_data   = arr_rword[DATA_W-1:0];
    assign par_err   = ^arr_rword;
`else
    assign arr_wword = arr_wdata;
    assign rd_data   = arr_rword;
    assign par_err   = 1'b0;
`endif

    dmem_array #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wword),
        .re_i    (rd_fire && in_range),
        .raddr_i (bus.req_addr[IDX_W-1:0]),
        .rdata_o (arr_rword)
    );

    // The read register only loads on accepted reads, so data holds while stalled.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = (rsp_valid_q && !oor_q) ? rd_data : '0;
    assign bus.rsp_err   = rsp_valid_q && (oor_q || par_err);

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        rsp_valid_d = rsp_valid_q;
        oor_d       = oor_q;
        if (state_q == INIT) begin
            sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
            if (sweep_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d     = RUN;
                sweep_cnt_d = '0;
            end
        end
        if (rd_fire) begin
            rsp_valid_d = 1'b1;
            oor_d       = !in_range;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            sweep_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            oor_q       <= oor_d;
        end
    end
endmodule
